decode_issue_queue: RTL and testbench

Parametrised instruction queue between fetch and decode, successor to the single-entry fetch-to-decode register. Accepts up to FETCH_WIDTH instructions per cycle and holds up to DEPTH entries in a circular buffer. Presents up to ISSUE_WIDTH in-order instructions per cycle to the decode lanes. Keeps each MIPS branch together with its delay slot, and isolates excepting entries so they issue as the youngest instruction of their group.

---
 rtl/decode_issue_queue_pkg.sv | 30 +++
 rtl/iq_issue_select.sv | 40 ++++
 rtl/decode_issue_queue.sv | 77 +++++++
 tb/tb_decode_issue_queue.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/decode_issue_queue_pkg.sv
// Shared types and sizing helpers for the fetch-to-decode instruction queue.
package decode_issue_queue_pkg;

   typedef logic [31:0] virt_t;
   typedef logic [31:0] uint32_t;

   // One queued instruction with its predecode and exception tags.
   typedef struct packed {
      virt_t       pc;
      uint32_t     inst;
      logic        is_br;
      logic        ex;
      logic [4:0]  exccode;
   } iq_entry_t;

   localparam int IQ_DEPTH       = 8;
   localparam int IQ_FETCH_WIDTH = 2;
   localparam int IQ_ISSUE_WIDTH = 2;

   // Width of a circular-buffer index.
   function automatic int ptr_bits(input int depth);
      return $clog2(depth);
   endfunction

   // Width of an occupancy counter that must also hold the value depth.
   function automatic int cnt_bits(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/iq_issue_select.sv
// Lane selection: decides which head candidates may issue this cycle.
// A branch only issues together with its delay slot in the same group, and
// an excepting entry closes the group so it is the youngest one issued.
module iq_issue_select
   import decode_issue_queue_pkg::*;
#(
   parameter int ISSUE_WIDTH = IQ_ISSUE_WIDTH,
   parameter int CW          = 4
) (
   input  iq_entry_t              cand [ISSUE_WIDTH],
   input  logic [CW-1:0]          count,
   output logic [ISSUE_WIDTH-1:0] out_valid,
   output iq_entry_t              out_entry [ISSUE_WIDTH]
);

   logic open_grp;
   logic lane_ok;

   assign out_entry = cand;

   // Walk the lanes oldest-first; the first lane that cannot go closes the group.
   always_comb begin
      out_valid = '0;
      open_grp  = 1'b1;
      lane_ok   = 1'b0;
      for (int k = 0; k < ISSUE_WIDTH; k++) begin
         lane_ok = (k < int'(count));
         // An excepting branch never needs its slot: the slot will not execute.
         if (cand[k].is_br && !cand[k].ex)
            lane_ok = lane_ok && (k + 1 < ISSUE_WIDTH) && (k + 1 < int'(count));
         if (open_grp && lane_ok)
            out_valid[k] = 1'b1;
         else
            open_grp = 1'b0;
         if (cand[k].ex)
            open_grp = 1'b0;
      end
   end

endmodule

// File: rtl/decode_issue_queue.sv
// Circular instruction queue between fetch and decode. Fetch pushes up to
// FETCH_WIDTH entries per cycle; decode sees up to ISSUE_WIDTH in-order
// head entries and consumes issue_cnt of them. All outputs depend only on
// registered state, so a pushed entry is visible one cycle later.
module decode_issue_queue
   import decode_issue_queue_pkg::*;
#(
   parameter int DEPTH       = IQ_DEPTH,
   parameter int FETCH_WIDTH = IQ_FETCH_WIDTH,
   parameter int ISSUE_WIDTH = IQ_ISSUE_WIDTH
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               flush,
   input  logic [FETCH_WIDTH-1:0]             in_valid,
   input  iq_entry_t                          in_entry [FETCH_WIDTH],
   output logic                               in_ready,
   output logic [ISSUE_WIDTH-1:0]             out_valid,
   output iq_entry_t                          out_entry [ISSUE_WIDTH],
   input  logic [$clog2(ISSUE_WIDTH+1)-1:0]   issue_cnt,
   output logic [$clog2(DEPTH+1)-1:0]         count
);

   localparam int PW = ptr_bits(DEPTH);
   localparam int CW = cnt_bits(DEPTH);

   iq_entry_t        mem [DEPTH];
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic             push_fire;
   logic [CW-1:0]    n_push;
   iq_entry_t        cand [ISSUE_WIDTH];

   // Ready only with room for a full fetch group, judged on the current count.
   assign in_ready  = (count <= CW'(DEPTH - FETCH_WIDTH));
   assign push_fire = (|in_valid) && in_ready;
   assign n_push    = push_fire ? CW'($countones(in_valid)) : '0;

   // Gather the head window; indices wrap naturally on the PW-bit pointer.
   always_comb begin
      for (int k = 0; k < ISSUE_WIDTH; k++)
         cand[k] = mem[head + PW'(k)];
   end

   // Pointer and occupancy update; flush and reset discard any same-cycle push.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         tail  <= tail + PW'(n_push);
         head  <= head + PW'(issue_cnt);
         count <= count + n_push - CW'(issue_cnt);
      end
   end

   // Entry storage; valid slots are contiguous from slot 0 so slot i lands at tail+i.
   always_ff @(posedge clk) begin
      if (push_fire && !flush && !reset) begin
         for (int i = 0; i < FETCH_WIDTH; i++)
            if (in_valid[i])
               mem[tail + PW'(i)] <= in_entry[i];
      end
   end

   iq_issue_select #(
      .ISSUE_WIDTH (ISSUE_WIDTH),
      .CW          (CW)
   ) u_select (
      .cand      (cand),
      .count     (count),
      .out_valid (out_valid),
      .out_entry (out_entry)
   );

endmodule

// File: tb/tb_decode_issue_queue.sv
// Bench for decode_issue_queue: directed steps followed by random traffic,
// all checked against a queue-based reference model.
module tb_decode_issue_queue;
  import decode_issue_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int FW    = 2;
  localparam int IW    = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            flush;
  logic [FW-1:0]   in_valid;
  iq_entry_t       in_entry [FW];
  logic            in_ready;
  logic [IW-1:0]   out_valid;
  iq_entry_t       out_entry [IW];
  logic [1:0]      issue_cnt;
  logic [3:0]      count;

  int checks   = 0;
  int failures = 0;
  iq_entry_t mq[$];

  decode_issue_queue #(.DEPTH(DEPTH), .FETCH_WIDTH(FW), .ISSUE_WIDTH(IW)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_entry  (in_entry),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_entry (out_entry),
    .issue_cnt (issue_cnt),
    .count     (count)
  );

  // clock
  always #5 clk = ~clk;

  function automatic iq_entry_t mk(input logic [31:0] pc, input bit br, input bit ex);
    iq_entry_t e;
    e.pc      = pc;
    e.inst    = pc ^ 32'hdead_beef;
    e.is_br   = br;
    e.ex      = ex;
    e.exccode = ex ? 5'd4 : 5'd0;
    return e;
  endfunction

  function automatic iq_entry_t rnd_entry();
    iq_entry_t e;
    int r;
    e.pc      = $urandom & 32'hffff_fffc;
    e.inst    = $urandom;
    r         = $urandom_range(0, 9);
    e.is_br   = (r < 3);
    e.ex      = (r == 9);
    e.exccode = e.ex ? 5'($urandom_range(1, 31)) : 5'd0;
    return e;
  endfunction

  // Reference lane rule: walk the model queue from its head.
  function automatic logic [IW-1:0] exp_mask();
    logic [IW-1:0] m;
    bit ok;
    m = '0;
    for (int k = 0; k < IW; k++) begin
      ok = (k < mq.size());
      if (ok && mq[k].is_br && !mq[k].ex)
        ok = (k + 1 < IW) && (k + 1 < mq.size());
      if (!ok) break;
      m[k] = 1'b1;
      if (mq[k].ex) break;
    end
    return m;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [IW-1:0] m;
    m = exp_mask();
    chk({tag, ".count"}, 128'(count), 128'(mq.size()));
    chk({tag, ".in_ready"}, 128'(in_ready), 128'((DEPTH - mq.size()) >= FW));
    chk({tag, ".out_valid"}, 128'(out_valid), 128'(m));
    for (int k = 0; k < IW; k++)
      if (m[k]) chk($sformatf("%s.lane%0d", tag, k), 128'(out_entry[k]), 128'(mq[k]));
  endtask

  // One clock: drive inputs, advance the model across the edge, check at negedge.
  task automatic step(input string tag, input int n, input iq_entry_t e0, input iq_entry_t e1,
                      input int issue, input bit fl);
    bit ready;
    in_valid    = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
    in_entry[0] = e0;
    in_entry[1] = e1;
    issue_cnt   = 2'(issue);
    flush       = fl;
    @(posedge clk);
    ready = (DEPTH - mq.size()) >= FW;
    if (fl) begin
      mq.delete();
    end else begin
      for (int i = 0; i < issue; i++) void'(mq.pop_front());
      if (ready && n >= 1) mq.push_back(e0);
      if (ready && n >= 2) mq.push_back(e1);
    end
    @(negedge clk);
    check_all(tag);
  endtask

  iq_entry_t z;

  initial begin
    z         = mk(32'h0, 1'b0, 1'b0);
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = '0;
    in_entry[0] = z;
    in_entry[1] = z;
    issue_cnt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mq.delete();
    check_all("reset");

    // two plain entries
    step("push2", 2, mk(32'h100, 0, 0), mk(32'h104, 0, 0), 0, 0);
    step("pop2", 0, z, z, 2, 0);

    // lone branch waits for its delay slot
    step("br_alone", 1, mk(32'h200, 1, 0), mk(32'h999, 0, 0), 0, 0);
    step("br_slot", 1, mk(32'h204, 0, 0), z, 0, 0);
    step("pop_br", 0, z, z, 2, 0);

    // branch in lane 1 holds back until it reaches lane 0
    step("nb_br", 2, mk(32'h300, 0, 0), mk(32'h304, 1, 0), 0, 0);
    step("slot_in", 1, mk(32'h308, 0, 0), z, 0, 0);
    step("issue1", 0, z, z, 1, 0);
    step("pop_pair", 0, z, z, 2, 0);

    // excepting entry closes the group
    step("ex_lane0", 2, mk(32'h400, 0, 1), mk(32'h404, 0, 0), 0, 0);
    step("ex_pop", 0, z, z, 1, 0);
    step("ex_rest", 0, z, z, 1, 0);

    // fill to full, then drain across the pointer wrap
    for (int i = 0; i < 4; i++)
      step($sformatf("fill%0d", i), 2, mk(32'h500 + 8 * i, 0, 0), mk(32'h504 + 8 * i, 0, 0), 0, 0);
    chk("full_ready", 128'(in_ready), 128'(0));
    step("push_full", 2, mk(32'h5f0, 0, 0), mk(32'h5f4, 0, 0), 0, 0);
    for (int i = 0; i < 3; i++)
      step($sformatf("drain%0d", i), 0, z, z, 2, 0);
    step("wrap_pushpop", 2, mk(32'h600, 0, 0), mk(32'h604, 0, 0), 2, 0);
    step("wrap_pop", 0, z, z, 1, 0);

    // flush beats a same-cycle push and pop
    step("pre_flush", 2, mk(32'h700, 0, 0), mk(32'h704, 0, 0), 0, 0);
    step("flush", 2, mk(32'h708, 0, 0), mk(32'h70c, 0, 0), 2, 1);
    chk("flush_count", 128'(count), 128'(0));
    chk("flush_valid", 128'(out_valid), 128'(0));
    chk("flush_ready", 128'(in_ready), 128'(1));

    // random traffic
    for (int c = 0; c < 600; c++) begin
      int n, iss;
      bit fl;
      n   = $urandom_range(0, FW);
      iss = $urandom_range(0, $countones(exp_mask()));
      if ($urandom_range(0, 3) == 0) iss = 0;
      fl  = ($urandom_range(0, 47) == 0);
      step("rand", n, rnd_entry(), rnd_entry(), iss, fl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
